// File: rtl/spi_master.sv
// Transmit-only SPI mode-0 master with an integrated write FIFO; each burst drains the FIFO under one cs_n.
// Optional macro SPI_MASTER_LSB_FIRST_EN shifts words LSB first (default build: MSB first).
module spi_master #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int SCLK_HALF  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  cs_n,
    input  logic                  fifo_wr_en,
    input  logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  fifo_empty,
    output logic                  fifo_full
);
    localparam int DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(SCLK_HALF - 1);
    localparam logic [BIT_W-1:0]      BIT_LAST = BIT_W'(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
`ifdef SPI_MASTER_LSB_FIRST_EN
    localparam int FIRST_IDX = 0;
    localparam int NEXT_IDX  = 1;
`else
    localparam int FIRST_IDX = DATA_WIDTH - 1;
    localparam int NEXT_IDX  = DATA_WIDTH - 2;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   r_wptr;
    logic [ADDR_WIDTH-1:0]   r_rptr;
    logic [ADDR_WIDTH:0]     r_count;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [DIV_W-1:0]        r_div;
    logic [BIT_W-1:0]        r_bit;
    logic                    r_busy;
    logic                    r_sclk;
    logic                    r_mosi;
    logic                    r_cs_n;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_empty;
    logic                    w_full;
    logic [DATA_WIDTH-1:0]   w_head;

    // The presented bit always sits at FIRST_IDX, so advancing is a rotate toward it.
    function automatic logic [DATA_WIDTH-1:0] rot_word(input logic [DATA_WIDTH-1:0] w);
`ifdef SPI_MASTER_LSB_FIRST_EN
        return {w[0], w[DATA_WIDTH-1:1]};
`else
        return {w[DATA_WIDTH-2:0], w[DATA_WIDTH-1]};
`endif
    endfunction

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_FULL);
    assign w_push  = fifo_wr_en && !w_full;
    assign w_pop   = (r_state == LOAD);
    assign w_head  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= fifo_wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_div   <= '0;
            r_bit   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && !w_empty) begin
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    r_shift <= w_head;
                    r_mosi  <= w_head[FIRST_IDX];
                    r_cs_n  <= 1'b0;
                    r_bit   <= '0;
                    r_div   <= '0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    if (r_div == DIV_LAST) begin
                        r_div  <= '0;
                        r_sclk <= ~r_sclk;
                        if (!r_sclk) begin
                            r_bit <= r_bit + 1'b1;
                        end else if (r_bit == BIT_LAST) begin
                            // Word finished on this falling edge: chain the next word or wind down.
                            r_state <= w_empty ? DONE : LOAD;
                        end else begin
                            r_shift <= rot_word(r_shift);
                            r_mosi  <= r_shift[NEXT_IDX];
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                DONE: begin
                    if (r_div == DIV_LAST) begin
                        r_div   <= '0;
                        r_cs_n  <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign sclk       = r_sclk;
    assign mosi       = r_mosi;
    assign cs_n       = r_cs_n;
    assign fifo_empty = w_empty;
    assign fifo_full  = w_full;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: bursts, empty start, FIFO overflow, mid-burst push and mid-word reset.
module tb_spi_master;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       fifo_wr_en = 1'b0;
    logic [7:0] fifo_wr_data = 8'h00;
    logic       busy, sclk, mosi, cs_n, fifo_empty, fifo_full;

    int vectors = 0;
    int miscompares = 0;

    logic cap_bits[$];
    int   cap_rise;
    int   cap_glitch;
    bit   stable_ok;

    always #5 clk = ~clk;

    spi_master #(
        .DATA_WIDTH(8),
        .FIFO_DEPTH(16),
        .ADDR_WIDTH(4),
        .SCLK_HALF (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .sclk        (sclk),
        .mosi        (mosi),
        .cs_n        (cs_n),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] get_byte(input int w);
        logic [7:0] r;
        r = 8'hxx;
        for (int b = 0; b < 8; b++) begin
            if (w * 8 + b < cap_bits.size()) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
                r[b] = cap_bits[w*8+b];
`else
                r[7-b] = cap_bits[w*8+b];
`endif
            end
        end
        return r;
    endfunction

    task automatic push(input logic [7:0] d);
        fifo_wr_en   = 1'b1;
        fifo_wr_data = d;
        tick();
        fifo_wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Follows a burst cycle by cycle, recording mosi at each sclk rising edge.
    task automatic capture(input int budget, input int push_at, input logic [7:0] push_val,
                           input int stop_rise);
        logic prev_sclk;
        bit   seen_cs;
        bit   ended;
        cap_bits.delete();
        cap_rise   = 0;
        cap_glitch = 0;
        seen_cs    = 1'b0;
        ended      = 1'b0;
        prev_sclk  = sclk;
        for (int c = 0; c < budget && !ended; c++) begin
            if (c == push_at) begin
                fifo_wr_en   = 1'b1;
                fifo_wr_data = push_val;
            end else begin
                fifo_wr_en = 1'b0;
            end
            tick();
            if (sclk && !prev_sclk) begin
                cap_bits.push_back(mosi);
                cap_rise++;
            end
            prev_sclk = sclk;
            if (!cs_n) seen_cs = 1'b1;
            else if (seen_cs && busy) cap_glitch++;
            if (!busy) ended = 1'b1;
            if (stop_rise > 0 && cap_rise == stop_rise) ended = 1'b1;
        end
        fifo_wr_en = 1'b0;
        if (!ended) check("capture_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_cs_n", cs_n, 1);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        rst_n = 1'b1;
        tick();

        // Two-word burst
        push(8'hA5);
        push(8'h3C);
        check("two_not_empty", fifo_empty, 0);
        pulse_start();
        check("two_busy_rise", busy, 1);
        check("two_cs_before_load", cs_n, 1);
        capture(400, -1, 8'h00, 0);
        check("two_rises", cap_rise, 16);
        check("two_byte0", get_byte(0), 8'hA5);
        check("two_byte1", get_byte(1), 8'h3C);
        check("two_cs_glitch", cap_glitch, 0);
        check("two_busy_end", busy, 0);
        check("two_cs_end", cs_n, 1);
        check("two_empty_end", fifo_empty, 1);
        check("two_mosi_end", mosi, 0);

        // Start with empty FIFO is ignored
        start = 1'b1;
        stable_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 0) start = 1'b0;
            if (busy !== 1'b0 || cs_n !== 1'b1 || sclk !== 1'b0) stable_ok = 1'b0;
        end
        check("empty_start_idle", stable_ok, 1);

        // Overflow: 17 pushes, the last is dropped
        for (int i = 0; i < 17; i++) begin
            push(8'(i));
            if (i == 15) check("full_after_16", fifo_full, 1);
            if (i == 14) check("not_full_at_15", fifo_full, 0);
        end
        check("full_after_17", fifo_full, 1);
        pulse_start();
        capture(4000, -1, 8'h00, 0);
        check("full_rises", cap_rise, 128);
        for (int w = 0; w < 16; w++) check($sformatf("full_byte%0d", w), get_byte(w), 32'(w));
        check("full_cs_glitch", cap_glitch, 0);
        check("full_empty_end", fifo_empty, 1);
        check("full_full_end", fifo_full, 0);

        // Push during the first word joins the same burst
        push(8'h81);
        pulse_start();
        capture(400, 5, 8'h7E, 0);
        check("mid_rises", cap_rise, 16);
        check("mid_byte0", get_byte(0), 8'h81);
        check("mid_byte1", get_byte(1), 8'h7E);
        check("mid_cs_glitch", cap_glitch, 0);
        check("mid_empty_end", fifo_empty, 1);

        // Reset in the 3rd bit of 0xFF with another byte still queued
        push(8'hFF);
        push(8'h55);
        pulse_start();
        capture(400, -1, 8'h00, 3);
        check("abort_mosi_pre", mosi, 1);
        check("abort_cs_pre", cs_n, 0);
        rst_n = 1'b0;
        tick();
        check("abort_cs_n", cs_n, 1);
        check("abort_sclk", sclk, 0);
        check("abort_mosi", mosi, 0);
        check("abort_busy", busy, 0);
        check("abort_empty", fifo_empty, 1);
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        stable_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 0) start = 1'b0;
            if (busy !== 1'b0 || cs_n !== 1'b1 || sclk !== 1'b0) stable_ok = 1'b0;
        end
        check("post_rst_start_idle", stable_ok, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Transmit-only SPI master (mode 0: CPOL=0, CPHA=0) with an integrated write FIFO.
- Host logic pushes bytes into the FIFO, then pulses start.
- The block drains the whole FIFO in one burst with cs_n held low throughout, MSB first.
- Sits between an on-chip producer and an external SPI slave.

Parameters:
- DATA_WIDTH, 8, bits per SPI word and FIFO entry width.
- FIFO_DEPTH, 16, number of FIFO entries.
- ADDR_WIDTH, 4, FIFO pointer width; must equal log2(FIFO_DEPTH).
- SCLK_HALF, 2, clk cycles per sclk half-period (min 1); default gives sclk = clk/4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  burst request; sampled every cycle.
- busy  output  1  high while a burst is in progress.
- sclk  output  1  SPI clock; idles low.
- mosi  output  1  SPI serial data out.
- cs_n  output  1  active-low chip select.
- fifo_wr_en  input  1  push fifo_wr_data this cycle.
- fifo_wr_data  input  DATA_WIDTH  data to push.
- fifo_empty  output  1  FIFO holds 0 entries.
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, busy=0, sclk=0, mosi=0, cs_n=1.
  - FIFO pointers and count are cleared: fifo_empty=1, fifo_full=0.
  - Reset mid-burst aborts immediately and discards all queued data.
- FIFO:
  - Circular buffer with wrapping ADDR_WIDTH-bit read/write pointers and a count of ADDR_WIDTH+1 bits.
  - fifo_empty and fifo_full are decoded from the registered count.
  - A push while full is ignored; data is lost and no state changes.
  - A push and a pop in the same cycle are both performed and the count is unchanged.
  - Pushes are accepted at any time, including during a burst.
- State machine: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - start=1 and fifo_empty=0: go to LOAD.
  - start=1 and fifo_empty=1: ignored; stay in IDLE, busy stays 0.
- LOAD (1 cycle):
  - Shift register takes the FIFO head and the FIFO pops.
  - cs_n becomes 0 and mosi takes the first bit (MSB).
  - Bit counter resets; divider counter resets; go to SHIFT.
- SHIFT:
  - The divider counts 0..SCLK_HALF-1; at terminal count sclk toggles.
  - Rising sclk edge: the slave samples; the bit counter increments.
  - Falling sclk edge, not the last bit: mosi advances to the next bit.
  - After the falling edge that follows the DATA_WIDTH-th rising edge:
    - If fifo_empty=0: go to LOAD. sclk stays low; cs_n stays low.
    - Otherwise: go to DONE.
  - Each word takes 1 + 2*SCLK_HALF*DATA_WIDTH clk cycles.
  - A byte pushed before the end of the current word is sent in the same burst.
- DONE:
  - Hold cs_n=0 and sclk=0 for SCLK_HALF cycles.
  - Then cs_n=1 and mosi=0 (both registered); go to IDLE.
- busy:
  - Registered; equals (state != IDLE).
  - Rises on the clk edge after start is accepted.
  - Falls in the same cycle cs_n returns high.
- start while busy is ignored.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro SPI_MASTER_LSB_FIRST_EN.
- Defined: each word is shifted LSB first; bit 0 is presented in LOAD.
- Undefined (default): MSB first, as described above.
- Timing, FIFO and handshake behaviour are identical in both builds.

Test Plan:
- Push 0xA5 then 0x3C on consecutive cycles, then pulse start for 1 cycle.
  - Required: busy rises next cycle and cs_n stays low across both words.
  - mosi sampled on sclk rising edges = 10100101 then 00111100.
  - 16 rising edges total, then busy=0, cs_n=1, fifo_empty=1.
- Pulse start with the FIFO empty -> busy, cs_n and sclk never change.
- Push 17 bytes 0x00..0x10 -> fifo_full=1 after the 16th push.
  - The 17th push is dropped.
  - A burst sends exactly 0x00..0x0F (128 sclk rising edges).
- Start a burst with 0x81 queued; push 0x7E during the first word.
  - Required: a single cs_n-low burst sends 0x81 then 0x7E.
- Drive rst_n low mid-word, in the 3rd bit of 0xFF.
  - Next edge: cs_n=1, sclk=0, mosi=0, busy=0, fifo_empty=1.
  - After release, start with the FIFO empty does nothing.
- Build with SPI_MASTER_LSB_FIRST_EN defined and send 0xA5 -> sampled bits 10100101 (LSB first).
